// File: rtl/cache_types_pkg.sv
// Shared types and constants for the 2-way set-associative L1 cache.
package cache_types_pkg;

  localparam int unsigned NUM_WAYS = 2;

  localparam logic DATA_SRC_CPU  = 1'b0;
  localparam logic DATA_SRC_MEM  = 1'b1;
  localparam logic PMEM_ADDR_CPU = 1'b0;
  localparam logic PMEM_ADDR_WB  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } cache_state_t;

  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic way);
    return way ? NUM_WAYS'(2'b10) : NUM_WAYS'(2'b01);
  endfunction

endpackage

// File: rtl/cache_control_if.sv
// Control-side bundle between the cache FSM, CPU port, arrays and pmem adaptor.
interface cache_control_if;
  import cache_types_pkg::*;

  logic                mem_read;
  logic                mem_write;
  logic                mem_resp;
  logic [NUM_WAYS-1:0] hit;
  logic [NUM_WAYS-1:0] valid_out;
  logic [NUM_WAYS-1:0] dirty_out;
  logic                lru_out;
  logic                arr_read;
  logic [NUM_WAYS-1:0] tag_load;
  logic [NUM_WAYS-1:0] valid_load;
  logic [NUM_WAYS-1:0] dirty_load;
  logic                dirty_in;
  logic                lru_load;
  logic                lru_in;
  logic [NUM_WAYS-1:0] data_we;
  logic                data_src;
  logic                pmem_addr_sel;
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_resp;

  modport master (
    input  mem_read, mem_write, hit, valid_out, dirty_out, lru_out, pmem_resp,
    output mem_resp, arr_read, tag_load, valid_load, dirty_load, dirty_in,
           lru_load, lru_in, data_we, data_src, pmem_addr_sel, pmem_read, pmem_write
  );

  modport slave (
    output mem_read, mem_write, hit, valid_out, dirty_out, lru_out, pmem_resp,
    input  mem_resp, arr_read, tag_load, valid_load, dirty_load, dirty_in,
           lru_load, lru_in, data_we, data_src, pmem_addr_sel, pmem_read, pmem_write
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for cache performance statistics.
module sat_counter #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] COUNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/cache_control.sv
// L1 cache controller FSM: hit service, dirty writeback, line fill and replay.
module cache_control
  import cache_types_pkg::*;
#(
  parameter int unsigned cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_control_if.master      bus,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count
);

  cache_state_t state, state_n;
  logic         replay_q, replay_n;
  logic         victim_q, victim_n;
  logic         hit_inc, miss_inc;

  logic req, any_hit, hit_way, victim_dirty;

  // Simultaneous match on both ways is illegal; way 0 wins.
  assign req          = bus.mem_read | bus.mem_write;
  assign any_hit      = |bus.hit;
  assign hit_way      = ~bus.hit[0];
  assign victim_dirty = bus.valid_out[bus.lru_out] & bus.dirty_out[bus.lru_out];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      replay_q <= 1'b0;
      victim_q <= 1'b0;
    end else begin
      state    <= state_n;
      replay_q <= replay_n;
      victim_q <= victim_n;
    end
  end

  always_comb begin
    state_n  = state;
    replay_n = replay_q;
    victim_n = victim_q;
    case (state)
      IDLE:      if (req) state_n = COMPARE;
      COMPARE: begin
        if (any_hit) begin
          replay_n = 1'b0;
          state_n  = IDLE;
        end else begin
          victim_n = bus.lru_out;
          state_n  = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: if (bus.pmem_resp) state_n = FILL;
      FILL: begin
        if (bus.pmem_resp) begin
          replay_n = 1'b1;
          state_n  = IDLE;
        end
      end
      default:   state_n = IDLE;
    endcase
  end

  // Reset forces every strobe low even though state is still the old one.
  always_comb begin
    bus.mem_resp      = 1'b0;
    bus.arr_read      = 1'b0;
    bus.tag_load      = '0;
    bus.valid_load    = '0;
    bus.dirty_load    = '0;
    bus.dirty_in      = 1'b0;
    bus.lru_load      = 1'b0;
    bus.lru_in        = 1'b0;
    bus.data_we       = '0;
    bus.data_src      = DATA_SRC_CPU;
    bus.pmem_addr_sel = PMEM_ADDR_CPU;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    hit_inc           = 1'b0;
    miss_inc          = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: bus.arr_read = req;
        COMPARE: begin
          if (any_hit) begin
            bus.mem_resp = 1'b1;
            bus.lru_load = 1'b1;
            bus.lru_in   = ~hit_way;
            hit_inc      = ~replay_q;
            if (bus.mem_write) begin
              bus.data_we    = way_onehot(hit_way);
              bus.data_src   = DATA_SRC_CPU;
              bus.dirty_load = way_onehot(hit_way);
              bus.dirty_in   = 1'b1;
            end
          end else begin
            miss_inc = 1'b1;
          end
        end
        WRITEBACK: begin
          bus.pmem_write    = 1'b1;
          bus.pmem_addr_sel = PMEM_ADDR_WB;
        end
        FILL: begin
          bus.pmem_read     = 1'b1;
          bus.pmem_addr_sel = PMEM_ADDR_CPU;
          if (bus.pmem_resp) begin
            bus.data_we    = way_onehot(victim_q);
            bus.data_src   = DATA_SRC_MEM;
            bus.tag_load   = way_onehot(victim_q);
            bus.valid_load = way_onehot(victim_q);
            bus.dirty_load = way_onehot(victim_q);
            bus.dirty_in   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.width(cnt_width)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.width(cnt_width)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: expected strobe sets queued per event, compared by a monitor.
module tb_cache_control;

  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  cache_control_if bus();

  cache_control #(.cnt_width(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  typedef struct packed {
    logic       mem_resp;
    logic       arr_read;
    logic [1:0] tag_load;
    logic [1:0] valid_load;
    logic [1:0] dirty_load;
    logic [1:0] data_we;
    logic       dirty_in;
    logic       lru_load;
    logic       lru_in;
    logic       data_src;
    logic       pmem_addr_sel;
    logic       pmem_read;
    logic       pmem_write;
  } obs_t;

  int    vectors = 0;
  int    miscompares = 0;
  obs_t  exp_q[$];
  string name_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t snap();
    obs_t o;
    o.mem_resp      = bus.mem_resp;
    o.arr_read      = bus.arr_read;
    o.tag_load      = bus.tag_load;
    o.valid_load    = bus.valid_load;
    o.dirty_load    = bus.dirty_load;
    o.data_we       = bus.data_we;
    o.dirty_in      = bus.dirty_in;
    o.lru_load      = bus.lru_load;
    o.lru_in        = bus.lru_in;
    o.data_src      = bus.data_src;
    o.pmem_addr_sel = bus.pmem_addr_sel;
    o.pmem_read     = bus.pmem_read;
    o.pmem_write    = bus.pmem_write;
    return o;
  endfunction

  function automatic logic [1:0] oh(input logic way);
    logic [1:0] r;
    r = 2'b00;
    r[way] = 1'b1;
    return r;
  endfunction

  task automatic push(input string name, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic exp_hit(input string name, input logic way, input logic wr);
    obs_t e = '0;
    e.mem_resp = 1'b1;
    e.lru_load = 1'b1;
    e.lru_in   = ~way;
    if (wr) begin
      e.data_we    = oh(way);
      e.dirty_load = oh(way);
      e.dirty_in   = 1'b1;
      e.data_src   = 1'b0;
    end
    push(name, e);
  endtask

  task automatic exp_fill(input string name, input logic way);
    obs_t e = '0;
    e.pmem_read  = 1'b1;
    e.data_we    = oh(way);
    e.tag_load   = oh(way);
    e.valid_load = oh(way);
    e.dirty_load = oh(way);
    e.data_src   = 1'b1;
    push(name, e);
  endtask

  task automatic exp_wb(input string name);
    obs_t e = '0;
    e.pmem_write    = 1'b1;
    e.pmem_addr_sel = 1'b1;
    push(name, e);
  endtask

  // Monitor: every CPU or memory completion is one scoreboard event.
  always @(negedge clk) begin
    if (!rst && (bus.mem_resp || bus.pmem_resp)) begin
      obs_t  got;
      obs_t  e;
      string n;
      got = snap();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event got=%h", got);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s got=%h expected=%h", n, got, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 2'b00;
    bus.valid_out = 2'b00;
    bus.dirty_out = 2'b00;
    bus.lru_out   = 1'b0;
    bus.pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    check("rst_outputs", 32'(snap()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_resp && n < 20);
    if (!bus.mem_resp) check({name, "_timeout"}, 32'(bus.mem_resp), 32'd1);
  endtask

  task automatic end_req();
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 2'b00;
  endtask

  // Answers the pending pmem request on its n-th asserted cycle.
  task automatic pmem_serve(input string name, input logic wr, input int n, input logic [1:0] next_hit);
    int seen = 0;
    int budget = 0;
    while (seen < n - 1 && budget < 50) begin
      @(negedge clk);
      budget++;
      if (wr ? bus.pmem_write : bus.pmem_read) seen++;
    end
    if (seen < n - 1) check({name, "_timeout"}, 32'(seen), 32'(n - 1));
    @(posedge clk); #1;
    bus.pmem_resp = 1'b1;
    bus.hit       = next_hit;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Read hit on way 1
    bus.mem_read = 1'b1;
    bus.hit      = 2'b10;
    @(negedge clk);
    check("rd_hit_arr_read", 32'(bus.arr_read), 32'd1);
    exp_hit("rd_hit_w1", 1'b1, 1'b0);
    wait_resp("rd_hit_w1");
    end_req();
    check("rd_hit_hit_count", 32'(hit_count), 32'd1);
    check("rd_hit_miss_count", 32'(miss_count), 32'd0);

    // Clean read miss, victim way 1, fill takes 5 cycles
    do_reset();
    bus.mem_read  = 1'b1;
    bus.lru_out   = 1'b1;
    bus.valid_out = 2'b10;
    exp_fill("clean_fill_w1", 1'b1);
    pmem_serve("clean_fill", 1'b0, 5, 2'b10);
    exp_hit("clean_replay_w1", 1'b1, 1'b0);
    wait_resp("clean_replay");
    end_req();
    check("clean_miss_count", 32'(miss_count), 32'd1);
    check("clean_hit_count", 32'(hit_count), 32'd0);

    // Dirty write miss, victim way 0: writeback then fill then replayed write
    do_reset();
    bus.mem_write = 1'b1;
    bus.lru_out   = 1'b0;
    bus.valid_out = 2'b01;
    bus.dirty_out = 2'b01;
    exp_wb("dirty_wb");
    pmem_serve("dirty_wb", 1'b1, 3, 2'b00);
    exp_fill("dirty_fill_w0", 1'b0);
    pmem_serve("dirty_fill", 1'b0, 2, 2'b01);
    exp_hit("dirty_replay_wr_w0", 1'b0, 1'b1);
    wait_resp("dirty_replay");
    end_req();
    check("dirty_miss_count", 32'(miss_count), 32'd1);
    check("dirty_hit_count", 32'(hit_count), 32'd0);

    // Both ways match and both strobes high: write to way 0
    do_reset();
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.hit       = 2'b11;
    exp_hit("dual_hit_wr_w0", 1'b0, 1'b1);
    wait_resp("dual_hit");
    end_req();
    check("dual_hit_count", 32'(hit_count), 32'd1);

    // Back-to-back reads with request held through the response
    do_reset();
    bus.mem_read = 1'b1;
    bus.hit      = 2'b01;
    exp_hit("b2b_first", 1'b0, 1'b0);
    exp_hit("b2b_second", 1'b0, 1'b0);
    wait_resp("b2b_first");
    @(negedge clk);
    check("b2b_no_dup_resp", 32'(bus.mem_resp), 32'd0);
    check("b2b_rearm_arr_read", 32'(bus.arr_read), 32'd1);
    wait_resp("b2b_second");
    end_req();
    check("b2b_hit_count", 32'(hit_count), 32'd2);

    // Reset in the middle of a fill
    do_reset();
    bus.mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("midfill_pmem_read", 32'(bus.pmem_read), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midfill_rst_pmem_read", 32'(bus.pmem_read), 32'd0);
    check("midfill_rst_mem_resp", 32'(bus.mem_resp), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_read = 1'b0;
    @(negedge clk);
    check("midfill_after_outputs", 32'(snap()), 32'h0);
    check("midfill_after_miss_count", 32'(miss_count), 32'd0);
    @(posedge clk); #1;
    bus.mem_read = 1'b1;
    bus.hit      = 2'b01;
    @(negedge clk);
    check("midfill_idle_arr_read", 32'(bus.arr_read), 32'd1);
    exp_hit("midfill_new_hit", 1'b0, 1'b0);
    wait_resp("midfill_new_hit");
    end_req();
    check("midfill_hit_count", 32'(hit_count), 32'd1);

    // Five first-pass hits saturate a 2-bit counter at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.mem_read = 1'b1;
      bus.hit      = 2'b10;
      exp_hit("sat_hit", 1'b1, 1'b0);
      wait_resp("sat_hit");
      end_req();
    end
    check("sat_hit_count", 32'(hit_count), 32'd3);
    check("sat_miss_count", 32'(miss_count), 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_control.md
Name: cache_control

Overview:
- Initiator-side FSM for the 2-way set-associative L1 cache.
- Drives the read/load strobes of the tag, valid, dirty, LRU and data `array` instances. Sequences CPU hits, dirty writeback and line fill against physical memory.
- Owns hit/miss performance counters.
- Sits between the CPU memory port and the cacheline adaptor. The datapath holds address, tags and compare logic.

Parameters:
cnt_width, 32, width of hit_count/miss_count (saturating)

Ports:
clk  in  1  clock
rst  in  1  reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  one-cycle completion pulse to CPU
hit  in  2  per-way tag match AND valid (from datapath, post array read)
valid_out  in  2  per-way valid bits from valid arrays
dirty_out  in  2  per-way dirty bits from dirty arrays
lru_out  in  1  LRU array output, way to evict
arr_read  out  1  read strobe to all arrays (index = CPU address index)
tag_load  out  2  per-way tag array load
valid_load  out  2  per-way valid array load (datain tied 1)
dirty_load  out  2  per-way dirty array load
dirty_in  out  1  dirty array datain
lru_load  out  1  LRU array load
lru_in  out  1  LRU datain
data_we  out  2  per-way data array write enable
data_src  out  1  0 = CPU write data/mask, 1 = pmem line
pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag + index (writeback)
pmem_read  out  1  line fill request, held until pmem_resp
pmem_write  out  1  writeback request, held until pmem_resp
pmem_resp  in  1  memory completion, pmem_rdata valid this cycle
hit_count  out  cnt_width  first-pass hits
miss_count  out  cnt_width  misses

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: state IDLE, replay_q 0, victim_q 0, counters 0. Every output deasserts/zeros in the reset cycle.
- Reset mid-operation abandons the transaction: no mem_resp, and pmem_read/pmem_write drop the next cycle. Arrays reset alongside.
- Arrays have 1-cycle registered read with same-index write forwarding. arr_read in cycle N → outputs valid in N+1. Outputs hold while arr_read is low.
- All outputs are combinational from state and inputs (Moore/Mealy mix), except the counters.
- IDLE:
  - If mem_read|mem_write: arr_read=1 → COMPARE.
  - Else stay in IDLE with all outputs 0.
- COMPARE (hit = |hit):
  - Read hit: mem_resp=1, lru_load=1, lru_in = ~hit way → IDLE.
  - Write hit: also data_we[way]=1, data_src=0, dirty_load[way]=1, dirty_in=1.
  - Hit counter: hit_count +1 only if replay_q=0. Clear replay_q.
  - Miss: victim_q <= lru_out, miss_count +1. Go to WRITEBACK if valid_out[lru_out] & dirty_out[lru_out], else FILL.
  - Both mem_read and mem_write high: treat as write.
  - hit==2'b11: illegal; resolve to way 0.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1.
  - On pmem_resp → FILL, else stay.
  - No timeout; unbounded wait.
- FILL:
  - pmem_read=1, pmem_addr_sel=0.
  - On pmem_resp, same cycle: data_we[victim_q]=1, data_src=1, tag_load[victim_q]=1, valid_load[victim_q]=1, dirty_load[victim_q]=1, dirty_in=0.
  - Then replay_q <= 1 → IDLE.
  - IDLE re-issues arr_read (CPU request still held) → COMPARE hits.
  - The replay hit applies LRU/write normally but is not counted.
- mem_resp is asserted only in COMPARE. CPU request signals are sampled only in IDLE/COMPARE, so back-to-back requests are safe.
- Counters saturate at 2**cnt_width-1. No wrap.
- Hit latency 2 cycles (IDLE→COMPARE). Clean miss: 2 + fill + 2. Dirty miss adds the writeback time.

Decomposition:
- Shared cache package `cache_types_pkg`:
  - enum `cache_state_t` {IDLE, COMPARE, WRITEBACK, FILL}
  - constants `NUM_WAYS=2`, `DATA_SRC_CPU=0`, `DATA_SRC_MEM=1`, `PMEM_ADDR_CPU=0`, `PMEM_ADDR_WB=1`
- Sub-module: `sat_counter` (params width; ports clk, rst, inc, count), instantiated twice for hit/miss.

Test Plan:
- Read hit, way 1 (hit=2'b10): mem_read → COMPARE next cycle → mem_resp, lru_load=1, lru_in=0 → hit_count=1, miss_count=0.
- Clean read miss: lru_out=1, valid_out=2'b10, dirty_out=0 → FILL, pmem_read held 5 cycles until pmem_resp. Required in the resp cycle: data_we=2'b10, tag_load=2'b10, dirty_in=0. Replay hits → mem_resp; miss_count=1, hit_count=0.
- Dirty write miss: lru_out=0, valid_out=2'b01, dirty_out=2'b01 → WRITEBACK (pmem_write, pmem_addr_sel=1) → FILL → replay sets dirty_load[0], dirty_in=1, data_src=0.
- Back-to-back reads: request held across the mem_resp cycle → no duplicate mem_resp; second request starts in IDLE the next cycle.
- rst asserted mid-FILL: next cycle pmem_read=0, state IDLE, counters 0, no mem_resp.
- Saturation with cnt_width=2: 5 hits → hit_count=3.
